// File: rtl/snd_pkg.sv
// snd_pkg: shared constants and helpers for the sound-command mailbox.
//   IRQ_LEVEL / IRQ_PULSE      : irq_n generation modes
//   OVF_DROP / OVF_OVERWRITE   : policy for a push into a full FIFO
//   HOLD_W                     : width of the pulse-mode hold counter
//   cnt_w()                    : occupancy width able to hold 0..DEPTH
package snd_pkg;

  localparam int IRQ_LEVEL     = 0;
  localparam int IRQ_PULSE     = 1;

  localparam int OVF_DROP      = 0;
  localparam int OVF_OVERWRITE = 1;

  localparam int HOLD_W        = 4;

  // Occupancy must represent DEPTH itself, hence DEPTH+1 states.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/snd_fifo_core.sv
// snd_fifo_core: storage, pointers and occupancy of the command FIFO, with a
// registered head output that always shows the oldest entry.
// The caller guarantees legality: push never occurs when full unless pop is
// also asserted, and pop never occurs when empty.
// Ports:
//   clk_sys, reset : clock, synchronous active-high reset
//   push, wr_data  : write wr_data at the tail
//   pop            : discard the head
//   rd_data        : registered head entry (holds its value while empty)
//   count          : occupancy 0..DEPTH
//   empty, full    : occupancy flags
module snd_fifo_core
  import snd_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    push,
  input  logic [DW-1:0]           wr_data,
  input  logic                    pop,
  output logic [DW-1:0]           rd_data,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    empty,
  output logic                    full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic [DW-1:0] head_nxt;

  // NOTE: every variable gets a value on every path through always_comb,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    rd_ptr_nxt = rd_ptr + AW'(pop);
    count_nxt  = count + CW'(push) - CW'(pop);
    // When the slot being written is about to become the head (push into
    // empty, or push+pop with a single entry) the array has not been
    // updated yet, so forward the incoming word.
    head_nxt   = (push && (wr_ptr == rd_ptr_nxt)) ? wr_data : mem[rd_ptr_nxt];
  end

  // NOTE: the storage array has no reset; pointers and count define which
  // entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      // With nothing left the head keeps its last value.
      if (count_nxt != '0) rd_data <= head_nxt;
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/snd_cmd_mailbox.sv
// snd_cmd_mailbox: main-CPU -> audio-CPU command channel. A DEPTH-entry FIFO
// with push/pop qualification, a drop-or-overwrite overflow policy, a sticky
// overflow flag and a level or held-pulse IRQ towards the audio CPU.
// Ports:
//   clk_sys, reset : system clock, synchronous active-high reset
//   wr_en, wr_data : producer push strobe and command word
//   rd_ce, rd_en   : consumer clock enable and pop request
//   rd_data        : registered head entry
//   irq_n          : active-low IRQ (level: non-empty; pulse: HOLD rd_ce ticks)
//   irq_ack        : pulse mode only, clears the hold counter
//   empty, full    : occupancy flags
//   count          : occupancy
//   ovf, ovf_clr   : sticky overflow flag and its clear
module snd_cmd_mailbox
  import snd_pkg::*;
#(
  parameter int DW       = 8,
  parameter int DEPTH    = 4,
  parameter int IRQ_MODE = IRQ_LEVEL,
  parameter int HOLD     = 3,
  parameter int OVF_MODE = OVF_DROP
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DW-1:0]           wr_data,
  input  logic                    rd_ce,
  input  logic                    rd_en,
  output logic [DW-1:0]           rd_data,
  output logic                    irq_n,
  input  logic                    irq_ack,
  output logic                    empty,
  output logic                    full,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  localparam logic [HOLD_W-1:0] HOLD_V = HOLD_W'(HOLD);

  logic              pop_ok;
  logic              push_ok;
  logic              ovf_evt;
  logic              core_pop;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;

  always_comb begin
    pop_ok   = rd_ce & rd_en & ~empty;
    // A full FIFO still takes a push when the same cycle frees a slot.
    push_ok  = wr_en & (~full | pop_ok | (OVF_MODE == OVF_OVERWRITE));
    ovf_evt  = wr_en & full & ~pop_ok;
    // Overwrite on full retires the oldest entry together with the write.
    core_pop = pop_ok | (push_ok & full);

    hold_nxt = hold_cnt;
    if (push_ok)                       hold_nxt = HOLD_V;
    else if (irq_ack)                  hold_nxt = '0;
    else if (rd_ce && hold_cnt != '0)  hold_nxt = hold_cnt - 1'b1;
  end

  snd_fifo_core #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_core (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (push_ok),
    .wr_data (wr_data),
    .pop     (core_pop),
    .rd_data (rd_data),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ovf      <= 1'b0;
      hold_cnt <= '0;
      irq_n    <= 1'b1;
    end else begin
      // A same-cycle overflow beats a clear so no event is ever lost.
      if (ovf_evt)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      hold_cnt <= hold_nxt;
      irq_n    <= (IRQ_MODE == IRQ_PULSE) ? (hold_cnt == '0) : empty;
    end
  end

endmodule

// File: tb/tb_snd_cmd_mailbox.sv
module tb_snd_cmd_mailbox;
  import snd_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = cnt_w(DEPTH);

  logic          clk_sys = 1'b0;
  logic          reset, wr_en, rd_ce, rd_en, irq_ack, ovf_clr;
  logic [DW-1:0] wr_data;

  // l_: level IRQ / drop, o_: level IRQ / overwrite, p_: pulse IRQ / drop
  logic [DW-1:0] l_rd_data, o_rd_data, p_rd_data;
  logic          l_irq_n, o_irq_n, p_irq_n;
  logic          l_empty, o_empty, p_empty;
  logic          l_full, o_full, p_full;
  logic [CW-1:0] l_count, o_count, p_count;
  logic          l_ovf, o_ovf, p_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_sys = ~clk_sys;

  snd_cmd_mailbox #(.DW(DW), .DEPTH(DEPTH), .IRQ_MODE(IRQ_LEVEL), .HOLD(3), .OVF_MODE(OVF_DROP)) u_lvl (
    .clk_sys(clk_sys), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_ce(rd_ce), .rd_en(rd_en),
    .rd_data(l_rd_data), .irq_n(l_irq_n), .irq_ack(irq_ack), .empty(l_empty), .full(l_full),
    .count(l_count), .ovf(l_ovf), .ovf_clr(ovf_clr));

  snd_cmd_mailbox #(.DW(DW), .DEPTH(DEPTH), .IRQ_MODE(IRQ_LEVEL), .HOLD(3), .OVF_MODE(OVF_OVERWRITE)) u_ovw (
    .clk_sys(clk_sys), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_ce(rd_ce), .rd_en(rd_en),
    .rd_data(o_rd_data), .irq_n(o_irq_n), .irq_ack(irq_ack), .empty(o_empty), .full(o_full),
    .count(o_count), .ovf(o_ovf), .ovf_clr(ovf_clr));

  snd_cmd_mailbox #(.DW(DW), .DEPTH(DEPTH), .IRQ_MODE(IRQ_PULSE), .HOLD(3), .OVF_MODE(OVF_DROP)) u_pls (
    .clk_sys(clk_sys), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_ce(rd_ce), .rd_en(rd_en),
    .rd_data(p_rd_data), .irq_n(p_irq_n), .irq_ack(irq_ack), .empty(p_empty), .full(p_full),
    .count(p_count), .ovf(p_ovf), .ovf_clr(ovf_clr));

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_data = '0; rd_ce = 1'b0; rd_en = 1'b0; irq_ack = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic push_seq(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_data = first + DW'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  // rd_ce low for one cycle, then high for one cycle.
  task automatic ce_tick();
    rd_ce = 1'b0; step();
    rd_ce = 1'b1; step();
    rd_ce = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; wr_en = 1'b1; wr_data = 8'hAA;
    repeat (3) step();
    reset = 1'b0; wr_en = 1'b0;
    step();
    n_checks++; if (l_empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", l_empty); else n_pass++;
    n_checks++; if (l_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", l_count); else n_pass++;
    n_checks++; if (l_irq_n !== 1'b1) $display("FAIL reset_irq_n: got %b expected 1", l_irq_n); else n_pass++;
    n_checks++; if (l_ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", l_ovf); else n_pass++;
    n_checks++; if ({l_full, l_rd_data} !== 9'h000) $display("FAIL reset_full_rd: got %h expected 000", {l_full, l_rd_data}); else n_pass++;
    n_checks++; if ({o_empty, o_full, o_ovf, o_irq_n, o_count, o_rd_data} !== 15'b1001_000_00000000)
      $display("FAIL reset_ovw: got %b expected 100100000000000", {o_empty, o_full, o_ovf, o_irq_n, o_count, o_rd_data}); else n_pass++;
    n_checks++; if ({p_empty, p_full, p_ovf, p_irq_n, p_count, p_rd_data} !== 15'b1001_000_00000000)
      $display("FAIL reset_pls: got %b expected 100100000000000", {p_empty, p_full, p_ovf, p_irq_n, p_count, p_rd_data}); else n_pass++;
  endtask

  task automatic test_fifo_order();
    logic [DW-1:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    wr_en = 1'b1; wr_data = 8'h11; step();
    n_checks++; if (l_rd_data !== 8'h11) $display("FAIL order_first_head: got %h expected 11", l_rd_data); else n_pass++;
    n_checks++; if (l_irq_n !== 1'b1) $display("FAIL order_irq_lag: got %b expected 1", l_irq_n); else n_pass++;
    wr_data = 8'h22; step();
    n_checks++; if (l_irq_n !== 1'b0) $display("FAIL order_irq_low: got %b expected 0", l_irq_n); else n_pass++;
    wr_data = 8'h33; step();
    wr_en = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat (5) step();
      n_checks++; if (l_count !== CW'(3 - i)) $display("FAIL order_no_ce_count%0d: got %0d expected %0d", i, l_count, 3 - i); else n_pass++;
      n_checks++; if (l_rd_data !== exp_d[i]) $display("FAIL order_rd%0d: got %h expected %h", i, l_rd_data, exp_d[i]); else n_pass++;
      rd_ce = 1'b1; step(); rd_ce = 1'b0;
    end
    n_checks++; if (l_empty !== 1'b1) $display("FAIL order_empty: got %b expected 1", l_empty); else n_pass++;
    n_checks++; if (l_irq_n !== 1'b0) $display("FAIL order_irq_still_low: got %b expected 0", l_irq_n); else n_pass++;
    step();
    n_checks++; if (l_irq_n !== 1'b1) $display("FAIL order_irq_high: got %b expected 1", l_irq_n); else n_pass++;
    rd_en = 1'b0;
  endtask

  task automatic test_ovf_drop();
    do_reset();
    push_seq(8'h01, 5);
    n_checks++; if ({l_full, l_count, l_ovf} !== 5'b1_100_1) $display("FAIL drop_state: got %b expected 11001", {l_full, l_count, l_ovf}); else n_pass++;
    rd_ce = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (l_rd_data !== DW'(i + 1)) $display("FAIL drop_rd%0d: got %h expected %h", i, l_rd_data, i + 1); else n_pass++;
      step();
    end
    // One extra pop on empty: no underflow, head unchanged.
    step();
    rd_ce = 1'b0; rd_en = 1'b0;
    n_checks++; if ({l_empty, l_count} !== 4'b1_000) $display("FAIL drop_underflow: got %b expected 1000", {l_empty, l_count}); else n_pass++;
    n_checks++; if (l_rd_data !== 8'h04) $display("FAIL drop_empty_rd: got %h expected 04", l_rd_data); else n_pass++;
    n_checks++; if (l_ovf !== 1'b1) $display("FAIL drop_ovf_sticky: got %b expected 1", l_ovf); else n_pass++;
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    n_checks++; if (l_ovf !== 1'b0) $display("FAIL drop_ovf_clr: got %b expected 0", l_ovf); else n_pass++;
  endtask

  task automatic test_ovf_overwrite();
    do_reset();
    push_seq(8'h01, 6);
    n_checks++; if ({o_full, o_count, o_ovf} !== 5'b1_100_1) $display("FAIL ovw_state: got %b expected 11001", {o_full, o_count, o_ovf}); else n_pass++;
    rd_ce = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (o_rd_data !== DW'(i + 3)) $display("FAIL ovw_rd%0d: got %h expected %h", i, o_rd_data, i + 3); else n_pass++;
      step();
    end
    rd_ce = 1'b0; rd_en = 1'b0;
    n_checks++; if ({o_empty, o_ovf} !== 2'b11) $display("FAIL ovw_end: got %b expected 11", {o_empty, o_ovf}); else n_pass++;
  endtask

  task automatic test_pulse_irq();
    // Single push: low for exactly three rd_ce ticks.
    do_reset();
    wr_en = 1'b1; wr_data = 8'h40; step(); wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ce_tick();
      n_checks++; if (p_irq_n !== 1'b0) $display("FAIL pulse_low_tick%0d: got %b expected 0", i, p_irq_n); else n_pass++;
    end
    step();
    n_checks++; if (p_irq_n !== 1'b1) $display("FAIL pulse_release: got %b expected 1", p_irq_n); else n_pass++;

    // Second push on tick 2 reloads the hold.
    do_reset();
    wr_en = 1'b1; wr_data = 8'h41; step(); wr_en = 1'b0;
    ce_tick();
    rd_ce = 1'b0; step();
    rd_ce = 1'b1; wr_en = 1'b1; wr_data = 8'h42; step();
    rd_ce = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ce_tick();
      n_checks++; if (p_irq_n !== 1'b0) $display("FAIL pulse_ext_tick%0d: got %b expected 0", i, p_irq_n); else n_pass++;
    end
    step();
    n_checks++; if (p_irq_n !== 1'b1) $display("FAIL pulse_ext_release: got %b expected 1", p_irq_n); else n_pass++;

    // irq_ack mid-hold, then ack colliding with a push.
    do_reset();
    wr_en = 1'b1; wr_data = 8'h43; step(); wr_en = 1'b0;
    step();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    n_checks++; if (p_irq_n !== 1'b0) $display("FAIL pulse_ack_lag: got %b expected 0", p_irq_n); else n_pass++;
    step();
    n_checks++; if (p_irq_n !== 1'b1) $display("FAIL pulse_ack_high: got %b expected 1", p_irq_n); else n_pass++;
    n_checks++; if (l_irq_n !== 1'b0) $display("FAIL level_ack_ignored: got %b expected 0", l_irq_n); else n_pass++;
    irq_ack = 1'b1; wr_en = 1'b1; wr_data = 8'h44; step();
    irq_ack = 1'b0; wr_en = 1'b0; step();
    n_checks++; if (p_irq_n !== 1'b0) $display("FAIL pulse_push_beats_ack: got %b expected 0", p_irq_n); else n_pass++;
  endtask

  task automatic test_boundary();
    logic [DW-1:0] exp_d [4] = '{8'hA2, 8'hA3, 8'hA4, 8'hB5};
    do_reset();
    push_seq(8'hA1, 4);
    wr_en = 1'b1; wr_data = 8'hB5; rd_ce = 1'b1; rd_en = 1'b1; step();
    wr_en = 1'b0; rd_ce = 1'b0; rd_en = 1'b0;
    n_checks++; if ({l_count, l_ovf} !== 4'b100_0) $display("FAIL full_pushpop: got %b expected 1000", {l_count, l_ovf}); else n_pass++;
    wr_en = 1'b1; wr_data = 8'hEE; ovf_clr = 1'b1; step();
    wr_en = 1'b0; ovf_clr = 1'b0;
    n_checks++; if ({l_count, l_ovf} !== 4'b100_1) $display("FAIL ovf_set_wins: got %b expected 1001", {l_count, l_ovf}); else n_pass++;
    rd_ce = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (l_rd_data !== exp_d[i]) $display("FAIL wrap_rd%0d: got %h expected %h", i, l_rd_data, exp_d[i]); else n_pass++;
      step();
    end
    rd_ce = 1'b0; rd_en = 1'b0;

    do_reset();
    wr_en = 1'b1; wr_data = 8'h5C; rd_ce = 1'b1; rd_en = 1'b1; step();
    n_checks++; if ({l_count, l_rd_data} !== 11'b001_01011100) $display("FAIL empty_pushpop: got %h expected 15c", {l_count, l_rd_data}); else n_pass++;
    wr_data = 8'h6D; step();
    wr_en = 1'b0; rd_ce = 1'b0; rd_en = 1'b0;
    n_checks++; if ({l_count, l_rd_data} !== 11'b001_01101101) $display("FAIL one_pushpop: got %h expected 16d", {l_count, l_rd_data}); else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_fifo_order();
    test_ovf_drop();
    test_ovf_overwrite();
    test_pulse_irq();
    test_boundary();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
